input_logic: RTL and testbench
==============================

Name: input_logic

Overview:
- Front-panel input block for the 10-bit processor; the input-side counterpart of the LED/hex output path.
- Synchronizes and debounces the two pushbuttons and synchronizes the 10 slide switches.
- Produces a single-cycle EXEC pulse with the switch word captured on DIN.
- Produces a clean, level PEEKb signal that selects bus or register viewing on the display.
- Sits between the board pins and the controller/output logic.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a button change (10 ms at 50 MHz; benches use 4)
DATA_W, 10, switch/data width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
SW  input  DATA_W  raw slide switches, asynchronous
KEY_EXEC  input  1  raw execute pushbutton, active-low, asynchronous
KEY_PEEK  input  1  raw peek pushbutton, active-low, asynchronous
BUSY  input  1  controller mid-instruction (high = ignore EXEC presses)
DIN  output  DATA_W  switch word captured at accepted EXEC press
EXEC  output  1  one-cycle pulse, accepted EXEC press
PEEKb  output  1  debounced peek level; 1 = released (show BUS), 0 = held (show REG)

Behaviour:
- Reset (asynchronous, active-high):
  - Synchronizer flops preset to 1 (released); SW synchronizers cleared to 0.
  - Both FSMs go to IDLE; counters = 0.
  - DIN = 0, EXEC = 0, PEEKb = 1.
  - Reset asserted mid-debounce or mid-press abandons that press; no EXEC is produced for it after reset releases until a new full press is seen.
- Synchronization:
  - Each KEY passes through a 2-flop synchronizer.
  - SW passes through a 2-flop synchronizer per bit.
  - Only synchronized values feed logic.
- Per-button debounce FSM (one instance for EXEC, one for PEEK), counter width clog2(DEBOUNCE_CYCLES+1):
  - IDLE: synchronized key = 1. If key = 0, go to DEB_PRESS with cnt = 1.
  - DEB_PRESS: if key = 1, return to IDLE with cnt = 0 (bounce rejected). Else if cnt = DEBOUNCE_CYCLES, go to PRESSED and emit accept strobe. Else cnt += 1.
  - PRESSED: if key = 1, go to DEB_RELEASE with cnt = 1.
  - DEB_RELEASE: if key = 0, return to PRESSED with cnt = 0. Else if cnt = DEBOUNCE_CYCLES, go to IDLE. Else cnt += 1.
  - A release glitch shorter than DEBOUNCE_CYCLES never produces a second press.
- EXEC:
  - Registered output. High for exactly one cycle at the edge after the EXEC FSM enters PRESSED, provided BUSY = 0 at that edge.
  - If BUSY = 1 at that edge, the press is discarded: not queued, not retried when BUSY falls.
  - Holding the key never repeats EXEC.
- DIN:
  - Loaded with synchronized SW at the same edge EXEC rises.
  - Otherwise holds its value; unaffected by SW changes between presses and by discarded (BUSY) presses.
- PEEKb:
  - 0 while the PEEK FSM is in PRESSED or DEB_RELEASE; 1 in IDLE or DEB_PRESS.
  - Registered; independent of BUSY.
- Latency: KEY_EXEC falls before edge 0 and stays low → EXEC high during the cycle after edge DEBOUNCE_CYCLES+3. PEEKb has the same latency for both falling and rising transitions.
- Simultaneous events: both buttons are fully independent. Simultaneous press yields EXEC and PEEKb = 0 on the same cycle.
- No counter overflow: each counter saturates at DEBOUNCE_CYCLES by construction.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset released, SW=10'h2A5, KEY_EXEC held low 20 cycles, BUSY=0 → exactly one EXEC pulse at cycle 7 after the fall; DIN=10'h2A5; DIN holds when SW changes to 10'h000.
2. KEY_EXEC bounces low 2 cycles, high 1, low 3, high → no EXEC; DIN unchanged; FSM back in IDLE.
3. Clean press with BUSY=1 at the accept edge → no EXEC, DIN unchanged. BUSY falls while the key is still held → still no EXEC. Release then re-press with BUSY=0 → one EXEC.
4. KEY_PEEK held low 10 cycles with a 2-cycle high glitch mid-hold → PEEKb goes 0 at +7 cycles, stays 0 through the glitch, and returns to 1 exactly 7 cycles after final release.
5. rst pulsed while the EXEC FSM is in DEB_PRESS (cnt=3), key kept low → outputs reset (DIN=0, PEEKb=1, EXEC=0). After reset release the held key is re-debounced: one EXEC at cycle 7 after release.
6. Both keys pressed on the same edge, BUSY=0 → EXEC pulse and PEEKb=0 asserted on the same cycle.

Source files
------------

// File: rtl/input_logic.sv
// Front-panel input block: synchronizes the switches and both pushbuttons, debounces the buttons,
// and produces a one-cycle EXEC pulse that captures DIN, plus a clean PEEKb level.
`timescale 1ns/1ps

module input_logic #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] SW,
    input  logic              KEY_EXEC,
    input  logic              KEY_PEEK,
    input  logic              BUSY,
    output logic [DATA_W-1:0] DIN,
    output logic              EXEC,
    output logic              PEEKb
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam int BTN_EXEC = 0;
    localparam int BTN_PEEK = 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } deb_state_t;

    logic [1:0]        key_meta_q;
    logic [1:0]        key_sync_q;
    logic [DATA_W-1:0] sw_meta_q;
    logic [DATA_W-1:0] sw_sync_q;

    logic [1:0]        accept;
    logic [1:0]        held;

    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] din_d;
    logic              exec_q;
    logic              exec_d;
    logic              peekb_q;
    logic              peekb_d;

    // Key synchronizers preset to the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_q <= 2'b11;
            key_sync_q <= 2'b11;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            key_meta_q <= {KEY_PEEK, KEY_EXEC};
            key_sync_q <= key_meta_q;
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_deb
        deb_state_t       state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             accept_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                accept_q <= 1'b0;
            end else begin
                accept_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (!key_sync_q[b]) begin
                            state_q <= DEB_PRESS;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    DEB_PRESS: begin
                        if (key_sync_q[b]) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q  <= PRESSED;
                            cnt_q    <= '0;
                            accept_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (key_sync_q[b]) begin
                            state_q <= DEB_RELEASE;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    DEB_RELEASE: begin
                        // A short release glitch falls back to PRESSED without a new accept.
                        if (!key_sync_q[b]) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign accept[b] = accept_q;
        assign held[b]   = (state_q == PRESSED) || (state_q == DEB_RELEASE);
    end

    // A press accepted while BUSY is simply dropped, never held over.
    always_comb begin
        exec_d  = accept[BTN_EXEC] & ~BUSY;
        din_d   = exec_d ? sw_sync_q : din_q;
        peekb_d = ~held[BTN_PEEK];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q   <= '0;
            exec_q  <= 1'b0;
            peekb_q <= 1'b1;
        end else begin
            din_q   <= din_d;
            exec_q  <= exec_d;
            peekb_q <= peekb_d;
        end
    end

    assign DIN   = din_q;
    assign EXEC  = exec_q;
    assign PEEKb = peekb_q;

endmodule

// File: tb/tb_input_logic.sv
// Bench for input_logic: directed front-panel scenarios plus random button/BUSY/switch traffic,
// all compared cycle by cycle against a run-length debounce model.
`timescale 1ns/1ps

module tb_input_logic;

    localparam int D = 4;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] SW;
    logic         KEY_EXEC;
    logic         KEY_PEEK;
    logic         BUSY;
    logic [W-1:0] DIN;
    logic         EXEC;
    logic         PEEKb;

    int n_tests = 0;
    int n_fail  = 0;

    input_logic #(.DEBOUNCE_CYCLES(D), .DATA_W(W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .SW       (SW),
        .KEY_EXEC (KEY_EXEC),
        .KEY_PEEK (KEY_PEEK),
        .BUSY     (BUSY),
        .DIN      (DIN),
        .EXEC     (EXEC),
        .PEEKb    (PEEKb)
    );

    always #5 clk = ~clk;

    // Reference: inputs reach the logic two edges late; a button's level flips once
    // D+1 consecutive delayed samples disagree with it.
    logic         ex_line[$];
    logic         pk_line[$];
    logic [W-1:0] sw_line[$];
    logic         m_lvl_ex, m_lvl_pk;
    int           m_run_ex, m_run_pk;
    logic         m_pend;
    logic         m_exec, m_peekb;
    logic [W-1:0] m_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ex_line  = '{1'b1, 1'b1};
        pk_line  = '{1'b1, 1'b1};
        sw_line  = '{'0, '0};
        m_lvl_ex = 1'b1;
        m_lvl_pk = 1'b1;
        m_run_ex = 0;
        m_run_pk = 0;
        m_pend   = 1'b0;
        m_exec   = 1'b0;
        m_peekb  = 1'b1;
        m_din    = '0;
    endtask

    task automatic model_step();
        logic         s_ex, s_pk;
        logic [W-1:0] s_sw;
        logic         newpress;
        s_ex = ex_line.pop_front();
        s_pk = pk_line.pop_front();
        s_sw = sw_line.pop_front();
        ex_line.push_back(KEY_EXEC);
        pk_line.push_back(KEY_PEEK);
        sw_line.push_back(SW);

        m_exec = m_pend && !BUSY;
        if (m_exec) m_din = s_sw;
        m_peekb = m_lvl_pk;

        newpress = 1'b0;
        if (s_ex != m_lvl_ex) m_run_ex++; else m_run_ex = 0;
        if (m_run_ex == D + 1) begin
            m_lvl_ex = ~m_lvl_ex;
            m_run_ex = 0;
            newpress = (m_lvl_ex == 1'b0);
        end
        m_pend = newpress;

        if (s_pk != m_lvl_pk) m_run_pk++; else m_run_pk = 0;
        if (m_run_pk == D + 1) begin
            m_lvl_pk = ~m_lvl_pk;
            m_run_pk = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check("exec", {31'd0, EXEC}, {31'd0, m_exec});
        check("peekb", {31'd0, PEEKb}, {31'd0, m_peekb});
        check("din", {22'd0, DIN}, {22'd0, m_din});
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check({tag, "_exec"}, {31'd0, EXEC}, 32'd0);
        check({tag, "_peekb"}, {31'd0, PEEKb}, 32'd1);
        check({tag, "_din"}, {22'd0, DIN}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_n(input int n, output int ex_first, output int ex_cnt, output int pk_fall);
        ex_first = -1;
        ex_cnt   = 0;
        pk_fall  = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (EXEC) begin
                ex_cnt++;
                if (ex_first < 0) ex_first = i;
            end
            if (!PEEKb && pk_fall < 0) pk_fall = i;
        end
    endtask

    initial begin
        int idx, cnt, pkf, pkr, hold_ex, hold_pk;

        rst      = 1'b1;
        SW       = '0;
        KEY_EXEC = 1'b1;
        KEY_PEEK = 1'b1;
        BUSY     = 1'b0;
        @(negedge clk);
        apply_reset("rst0");

        // Clean press: one pulse, latency 7, DIN captured and held.
        SW       = 10'h2A5;
        KEY_EXEC = 1'b0;
        run_n(20, idx, cnt, pkf);
        check("t1_lat", idx, 32'd7);
        check("t1_cnt", cnt, 32'd1);
        check("t1_din", {22'd0, DIN}, 32'h2A5);
        SW       = 10'h000;
        KEY_EXEC = 1'b1;
        run_n(12, idx, cnt, pkf);
        check("t1_hold", {22'd0, DIN}, 32'h2A5);

        // Bouncy press never reaches the threshold.
        KEY_EXEC = 1'b0; step(); step();
        KEY_EXEC = 1'b1; step();
        KEY_EXEC = 1'b0; step(); step(); step();
        KEY_EXEC = 1'b1;
        run_n(12, idx, cnt, pkf);
        check("t2_cnt", cnt, 32'd0);
        check("t2_din", {22'd0, DIN}, 32'h2A5);

        // BUSY at the accept edge discards the press even after BUSY drops.
        SW       = 10'h3C3;
        KEY_EXEC = 1'b0;
        BUSY     = 1'b1;
        cnt      = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) BUSY = 1'b0;
            step();
            if (EXEC) cnt++;
        end
        check("t3_busy_cnt", cnt, 32'd0);
        check("t3_busy_din", {22'd0, DIN}, 32'h2A5);
        KEY_EXEC = 1'b1;
        run_n(12, idx, cnt, pkf);
        SW       = 10'h155;
        KEY_EXEC = 1'b0;
        run_n(20, idx, cnt, pkf);
        check("t3_lat", idx, 32'd7);
        check("t3_cnt", cnt, 32'd1);
        check("t3_din", {22'd0, DIN}, 32'h155);
        KEY_EXEC = 1'b1;
        run_n(12, idx, cnt, pkf);

        // PEEK hold with a 2-cycle release glitch.
        pkf = -1;
        pkr = -1;
        for (int i = 0; i < 30; i++) begin
            KEY_PEEK = (i < 6) ? 1'b0 : (i < 8) ? 1'b1 : (i < 12) ? 1'b0 : 1'b1;
            step();
            if (!PEEKb && pkf < 0) pkf = i;
            if (PEEKb && pkf >= 0 && pkr < 0) pkr = i;
        end
        check("t4_fall", pkf, 32'd7);
        check("t4_rise", pkr, 32'd19);

        // Reset mid-debounce abandons the press; the held key is re-debounced.
        SW       = 10'h011;
        KEY_EXEC = 1'b0;
        KEY_PEEK = 1'b0;
        run_n(10, idx, cnt, pkf);
        KEY_EXEC = 1'b1;
        run_n(10, idx, cnt, pkf);
        KEY_EXEC = 1'b0;
        run_n(5, idx, cnt, pkf);
        check("t5_pre_cnt", cnt, 32'd0);
        apply_reset("t5_rst");
        run_n(20, idx, cnt, pkf);
        check("t5_lat", idx, 32'd7);
        check("t5_cnt", cnt, 32'd1);
        check("t5_peek", pkf, 32'd7);
        KEY_EXEC = 1'b1;
        KEY_PEEK = 1'b1;
        run_n(12, idx, cnt, pkf);

        // Simultaneous press: EXEC and PEEKb=0 on the same cycle.
        SW       = 10'h0F0;
        KEY_EXEC = 1'b0;
        KEY_PEEK = 1'b0;
        run_n(12, idx, cnt, pkf);
        check("t6_exec", idx, 32'd7);
        check("t6_peek", pkf, 32'd7);
        check("t6_din", {22'd0, DIN}, 32'h0F0);
        KEY_EXEC = 1'b1;
        KEY_PEEK = 1'b1;
        run_n(12, idx, cnt, pkf);

        // Random traffic against the model.
        hold_ex = 0;
        hold_pk = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold_ex == 0) begin
                KEY_EXEC = 1'($urandom_range(0, 1));
                hold_ex  = int'($urandom_range(1, 10));
            end
            if (hold_pk == 0) begin
                KEY_PEEK = 1'($urandom_range(0, 1));
                hold_pk  = int'($urandom_range(1, 10));
            end
            hold_ex--;
            hold_pk--;
            BUSY = ($urandom_range(0, 3) == 0);
            SW   = W'($urandom_range(0, 1023));
            if ($urandom_range(0, 249) == 0) apply_reset("rnd_rst");
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
